latch_bank_write_arbiter: RTL and testbench
===========================================

// Module: latch_bank_write_arbiter
// PURPOSE
//   Shares one bank of level-sensitive D latches between NREQ write requesters.
//   Grants requesters round-robin, one at a time.
//   Sequences each write as SETUP -> OPEN -> HOLD, so latch_d is stable before
//   latch_en rises and after it falls; no latch ever sees d change while open.
//   Sits between requester logic and the d_latch array; the latches' own rstn is driven separately.
// PARAMETERS
//   NREQ      4  number of requesters (>=2)
//   WIDTH     8  data width of each latch word
//   DEPTH     4  number of latch words in the bank
//   AW        2  address width, must be >= clog2(DEPTH)
//   EN_CYCLES 2  cycles latch_en is held high per write (>=1)
// PORTS
//   clk       in   1           system clock, rising edge
//   rstn      in   1           synchronous active-low reset
//   req       in   NREQ        write request per requester, held until ack
//   wdata     in   NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
//   waddr     in   NREQ*AW     word address, requester i at [i*AW +: AW]
//   ack       out  NREQ        one-cycle completion pulse to granted requester
//   err       out  1           one-cycle pulse with ack when waddr >= DEPTH
//   latch_d   out  WIDTH       shared data bus to all latches
//   latch_en  out  DEPTH       one-hot enable, one bit per latch word
//   busy      out  1           high in any state except IDLE
//   grant_id  out  clog2(NREQ) index of requester currently served
// BEHAVIOUR
// - Reset: clk is the only clock; rstn is synchronous, active-low.
//   - While rstn is 0 at a rising edge, these are 0 after that edge: state=IDLE,
//     rr pointer, ack, err, latch_d, latch_en, busy and grant_id.
//   - Reset mid-write aborts it: latch_en drops at that edge and no ack is issued.
// - FSM states and transitions:
//   - IDLE: if any req bit is 1, grant the first set bit at or after the rr pointer
//     (wrapping NREQ-1 -> 0). Capture wdata, waddr and grant_id. Go to SETUP.
//   - SETUP (1 cycle): latch_d = captured data, latch_en = 0. Go to OPEN.
//   - OPEN (EN_CYCLES cycles): latch_en[addr] = 1, latch_d unchanged. A down-counter
//     reloads to EN_CYCLES-1 on SETUP->OPEN. Leave for HOLD when it reaches 0.
//   - HOLD (1 cycle): latch_en = 0, latch_d unchanged.
//     - ack[grant_id] = 1 this cycle; err = 1 if addr >= DEPTH.
//     - rr pointer becomes grant_id+1 (mod NREQ). Go to IDLE.
// - Latency: req sampled in IDLE at edge 0; ack high in cycle 2+EN_CYCLES; back in
//   IDLE next cycle. A write occupies 3+EN_CYCLES cycles, IDLE included.
// - Outputs are registered. latch_d holds the last written value in IDLE.
// - Requests and captured values:
//   - Inputs are captured only in IDLE. req, wdata or waddr changing after grant have
//     no effect, and dropping req mid-write does not abort it.
//   - The requester must drop req on the edge that samples ack. A req still high in
//     the following IDLE is a new request; rr rotation stops it starving others.
// - Out of range: if addr >= DEPTH, latch_en stays all 0 for the whole sequence.
//   Timing is identical, ack is still issued and err pulses with it.
// - Simultaneous requests: exactly one grant. Every active requester is served
//   within NREQ writes.
// - Invariants: latch_en is at most one-hot and is never high in SETUP, HOLD or IDLE.
//   latch_d never changes while any latch_en bit is 1.
// TESTING
// - Reset: rstn=0 for 2 cycles while req=4'b1111 -> ack=0, latch_en=0, busy=0;
//   after release grant_id=0 first.
// - Single write: req[2]=1, wdata2=8'hA5, waddr2=3, EN_CYCLES=2 -> SETUP 1 cycle,
//   latch_en=4'b1000 for 2 cycles, ack=4'b0100 in cycle 4; a d_latch model holds 8'hA5.
// - Round-robin: req=4'b1111 held with each ack -> grant order 0,1,2,3,0; each write
//   takes 5 cycles incl. IDLE.
// - Out of range: DEPTH=3, waddr=3 -> latch_en stays 0, ack and err pulse together,
//   bank contents unchanged.
// - Mid-op events: change wdata0 during OPEN -> latch_d unchanged; drop req0 in SETUP
//   -> write completes with ack; assert rstn=0 in OPEN -> latch_en=0 next edge, no ack.
// - Random soak: $random req/data/addr for 1000 cycles -> a checker confirms the
//   invariants hold every cycle and the bank model matches the expected contents.

Source files
------------

// File: rtl/latch_bank_write_arbiter.sv
// Round-robin write arbiter for a shared bank of level-sensitive D latches.
// Each write runs SETUP -> OPEN -> HOLD so latch_d is stable around every enable pulse.
module latch_bank_write_arbiter #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned AW        = 2,
    parameter int unsigned EN_CYCLES = 2
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     wdata,
    input  logic [NREQ*AW-1:0]        waddr,
    output logic [NREQ-1:0]           ack,
    output logic                      err,
    output logic [WIDTH-1:0]          latch_d,
    output logic [DEPTH-1:0]          latch_en,
    output logic                      busy,
    output logic [$clog2(NREQ)-1:0]   grant_id
);

    localparam int unsigned GW = $clog2(NREQ);
    localparam int unsigned CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        OPEN  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t            r_state;
    logic [GW-1:0]     r_rr;
    logic [GW-1:0]     r_gid;
    logic [AW-1:0]     r_addr;
    logic [CW-1:0]     r_cnt;
    logic [NREQ-1:0]   r_ack;
    logic              r_err;
    logic [WIDTH-1:0]  r_latch_d;
    logic [DEPTH-1:0]  r_latch_en;
    logic              r_busy;

    state_t            w_state;
    logic [GW-1:0]     w_rr;
    logic [GW-1:0]     w_gid;
    logic [AW-1:0]     w_addr;
    logic [CW-1:0]     w_cnt;
    logic [NREQ-1:0]   w_ack;
    logic              w_err;
    logic [WIDTH-1:0]  w_latch_d;
    logic [DEPTH-1:0]  w_latch_en;
    logic              w_busy;

    logic [WIDTH-1:0]  w_wdata_arr [NREQ];
    logic [AW-1:0]     w_waddr_arr [NREQ];
    logic              w_found;
    logic [GW-1:0]     w_pick;
    logic [GW-1:0]     w_idx;
    logic              w_addr_ok;
    logic [DEPTH-1:0]  w_onehot;

    // Unpack the flat per-requester buses
    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            w_wdata_arr[i] = wdata[i*WIDTH +: WIDTH];
            w_waddr_arr[i] = waddr[i*AW +: AW];
        end
    end

    // First requesting index at or after the rr pointer, wrapping
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_idx   = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = GW'((32'(r_rr) + 32'(i)) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_pick  = w_idx;
            end
        end
    end

    assign w_addr_ok = (32'(r_addr) < DEPTH);
    assign w_onehot  = w_addr_ok ? (DEPTH'(1) << r_addr) : '0;

    // Next-state and next-output logic
    always_comb begin
        w_state    = r_state;
        w_rr       = r_rr;
        w_gid      = r_gid;
        w_addr     = r_addr;
        w_cnt      = r_cnt;
        w_latch_d  = r_latch_d;
        w_ack      = '0;
        w_err      = 1'b0;
        w_latch_en = '0;

        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state   = SETUP;
                    w_gid     = w_pick;
                    w_addr    = w_waddr_arr[w_pick];
                    w_latch_d = w_wdata_arr[w_pick];
                end
            end
            SETUP: begin
                w_state    = OPEN;
                w_cnt      = CW'(EN_CYCLES - 1);
                w_latch_en = w_onehot;
            end
            OPEN: begin
                if (r_cnt == '0) begin
                    w_state = HOLD;
                    w_ack   = NREQ'(1) << r_gid;
                    w_err   = !w_addr_ok;
                end else begin
                    w_cnt      = r_cnt - CW'(1);
                    w_latch_en = w_onehot;
                end
            end
            HOLD: begin
                w_state = IDLE;
                w_rr    = (32'(r_gid) == NREQ - 1) ? '0 : r_gid + GW'(1);
            end
            default: w_state = IDLE;
        endcase

        w_busy = (w_state != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state    <= IDLE;
            r_rr       <= '0;
            r_gid      <= '0;
            r_addr     <= '0;
            r_cnt      <= '0;
            r_ack      <= '0;
            r_err      <= 1'b0;
            r_latch_d  <= '0;
            r_latch_en <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_rr       <= w_rr;
            r_gid      <= w_gid;
            r_addr     <= w_addr;
            r_cnt      <= w_cnt;
            r_ack      <= w_ack;
            r_err      <= w_err;
            r_latch_d  <= w_latch_d;
            r_latch_en <= w_latch_en;
            r_busy     <= w_busy;
        end
    end

    assign ack      = r_ack;
    assign err      = r_err;
    assign latch_d  = r_latch_d;
    assign latch_en = r_latch_en;
    assign busy     = r_busy;
    assign grant_id = r_gid;

endmodule

// File: tb/tb_latch_bank_write_arbiter.sv
// Scoreboard bench for latch_bank_write_arbiter: a cycle-count timeline model predicts
// each write; a negedge monitor checks outputs, invariants and a latch bank model.
module tb_latch_bank_write_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 3;
    localparam int unsigned EN    = 2;
    localparam int unsigned GW    = 2;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ*AW-1:0]    waddr;
    logic [NREQ-1:0]       ack;
    logic                  err;
    logic [WIDTH-1:0]      latch_d;
    logic [DEPTH-1:0]      latch_en;
    logic                  busy;
    logic [GW-1:0]         grant_id;

    always #5 clk = ~clk;

    latch_bank_write_arbiter #(
        .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW), .EN_CYCLES(EN)
    ) dut (
        .clk(clk), .rstn(rstn), .req(req), .wdata(wdata), .waddr(waddr),
        .ack(ack), .err(err), .latch_d(latch_d), .latch_en(latch_en),
        .busy(busy), .grant_id(grant_id)
    );

    typedef struct {
        int               gid;
        logic [WIDTH-1:0] data;
        int               addr;
        bit               bad;
        int               cyc;
    } exp_t;

    exp_t             sb[$];
    int               n_chk = 0;
    int               n_err = 0;
    int               cyc   = 0;
    int               m_rem = 0;
    int               m_rr  = 0;
    int               m_gid = 0;
    int               m_addr = 0;
    logic [WIDTH-1:0] m_data = '0;
    logic [DEPTH-1:0] m_en   = '0;
    logic [WIDTH-1:0] bank     [DEPTH];
    logic [WIDTH-1:0] exp_bank [DEPTH];
    logic [WIDTH-1:0] prev_d = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Timeline model: a grant at edge g opens the latch after edges g+1..g+EN,
    // acks after edge g+1+EN and samples requests again at edge g+3+EN.
    always @(posedge clk) begin
        int pick;
        cyc++;
        if (!rstn) begin
            m_rem  = 0;
            m_rr   = 0;
            m_gid  = 0;
            m_addr = 0;
            m_data = '0;
            sb.delete();
        end else if (m_rem > 0) begin
            m_rem--;
        end else if (req != '0) begin
            pick = -1;
            for (int k = 0; k < NREQ; k++)
                if (pick < 0 && req[(m_rr + k) % NREQ]) pick = (m_rr + k) % NREQ;
            m_gid  = pick;
            m_data = wdata[pick*WIDTH +: WIDTH];
            m_addr = int'(waddr[pick*AW +: AW]);
            m_rem  = 2 + EN;
            m_rr   = (pick + 1) % NREQ;
            sb.push_back('{pick, m_data, m_addr, (m_addr >= int'(DEPTH)), cyc + 1 + EN});
        end
        m_en = (m_rem >= 2 && m_rem <= EN + 1 && m_addr < int'(DEPTH)) ? (DEPTH'(1) << m_addr) : '0;
        if (m_en != '0) exp_bank[m_addr] = m_data;
    end

    // Monitor: latch bank model, per-cycle checks, scoreboard pop on ack
    always @(negedge clk) begin
        exp_t e;
        for (int i = 0; i < DEPTH; i++) if (latch_en[i]) bank[i] = latch_d;
        chk("latch_en", 32'(latch_en), 32'(m_en));
        chk("busy", 32'(busy), 32'(m_rem > 0));
        chk("ack_vec", 32'(ack), (m_rem == 1) ? (32'd1 << m_gid) : 32'd0);
        chk("err_bit", 32'(err), 32'(m_rem == 1 && m_addr >= int'(DEPTH)));
        chk("latch_d", 32'(latch_d), 32'(m_data));
        chk("grant_id", 32'(grant_id), 32'(m_gid));
        chk("en_onehot", 32'($countones(latch_en) <= 1), 32'd1);
        if (latch_en != '0) chk("d_stable_open", 32'(latch_d), 32'(prev_d));
        if (ack != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_ack_id", 32'(ack), 32'd1 << e.gid);
                chk("sb_err", 32'(err), 32'(e.bad));
                chk("sb_ack_time", 32'(cyc), 32'(e.cyc));
                if (!e.bad) chk("sb_bank_word", 32'(bank[e.addr]), 32'(e.data));
                for (int i = 0; i < DEPTH; i++) chk("sb_bank", 32'(bank[i]), 32'(exp_bank[i]));
            end
        end
        prev_d = latch_d;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [WIDTH-1:0] d, input int a);
        wdata[id*WIDTH +: WIDTH] = d;
        waddr[id*AW +: AW]       = AW'(a);
        req[id]                  = 1'b1;
    endtask

    task automatic wait_ack(input int id);
        int n = 0;
        while (!ack[id] && n < 40) begin
            step();
            n++;
        end
        chk("ack_seen", 32'(ack[id]), 32'd1);
        req[id] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) begin
            bank[i]     = '0;
            exp_bank[i] = '0;
        end
        rstn  = 1'b0;
        req   = '1;
        wdata = '0;
        waddr = '0;
        step();
        step();

        // Round-robin with all requests held: order 0,1,2,3,0
        wdata = 32'h44332211;
        waddr = {3'd3, 3'd2, 3'd1, 3'd0};
        rstn  = 1'b1;
        repeat (21) step();
        req = '0;
        repeat (6) step();

        // Single write from requester 2
        set_req(2, 8'hA5, 3);
        wait_ack(2);
        repeat (3) step();
        chk("bank3_a5", 32'(bank[3]), 32'h0A5);

        // Out-of-range address
        set_req(0, 8'h3C, 5);
        wait_ack(0);
        repeat (3) step();

        // Drop req in SETUP, change data in OPEN
        set_req(0, 8'h5A, 1);
        step();
        req[0] = 1'b0;
        step();
        wdata[0 +: WIDTH] = 8'hFF;
        wait_ack(0);
        repeat (3) step();
        chk("bank1_5a", 32'(bank[1]), 32'h05A);

        // Reset during OPEN aborts without ack
        set_req(1, 8'h77, 2);
        step();
        step();
        rstn = 1'b0;
        step();
        rstn = 1'b1;
        req  = '0;
        repeat (6) step();

        // Random soak
        for (int t = 0; t < 1000; t++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i]) req[i] = 1'b0;
                else if (!req[i] && $urandom_range(0, 3) == 0)
                    set_req(i, WIDTH'($urandom), int'($urandom_range(0, 5)));
                else if ($urandom_range(0, 9) == 0)
                    wdata[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            end
            rstn = ($urandom_range(0, 249) != 0);
            step();
        end
        rstn = 1'b1;
        req  = '0;
        repeat (10) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        for (int i = 0; i < DEPTH; i++) chk("final_bank", 32'(bank[i]), 32'(exp_bank[i]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
